// File: rtl/fb_writer.sv
// Frame-buffer writer: plots a pixel, fills a clipped rectangle or clears the
// screen, issuing one frame-memory write per cycle in raster order.
`timescale 1ns/1ps
module fb_writer #(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 240
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [8:0]  cmd_x0,
  input  logic [8:0]  cmd_x1,
  input  logic [7:0]  cmd_y0,
  input  logic [7:0]  cmd_y1,
  input  logic [7:0]  cmd_color,
  output logic        wr_en,
  output logic [16:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, DONE = 2'd2} state_t;

  localparam logic [8:0]  X_MAX = 9'(WIDTH - 1);
  localparam logic [7:0]  Y_MAX = 8'(HEIGHT - 1);
  localparam logic [16:0] W17   = 17'(WIDTH);

  state_t      state;
  logic [8:0]  x_cur, x_first, x_last;
  logic [7:0]  y_cur, y_last;
  logic [16:0] row_base;

  logic [8:0]  x_lo, x_hi;
  logic [7:0]  y_lo, y_hi;
  logic        reject;

  assign dbg_state = state;

  // Normalise every op to an inclusive rectangle and decide rejection.
  always_comb begin
    x_lo   = cmd_x0;
    x_hi   = cmd_x0;
    y_lo   = cmd_y0;
    y_hi   = cmd_y0;
    reject = 1'b0;
    case (cmd_op)
      2'b00: reject = (cmd_x0 > X_MAX) || (cmd_y0 > Y_MAX);
      2'b01: begin
        x_hi   = (cmd_x1 > X_MAX) ? X_MAX : cmd_x1;
        y_hi   = (cmd_y1 > Y_MAX) ? Y_MAX : cmd_y1;
        reject = (cmd_x0 > X_MAX) || (cmd_y0 > Y_MAX) ||
                 (cmd_x0 > x_hi) || (cmd_y0 > y_hi);
      end
      2'b10: begin
        x_lo = '0;
        x_hi = X_MAX;
        y_lo = '0;
        y_hi = Y_MAX;
      end
      default: reject = 1'b1;
    endcase
  end

  // Handshake: a command is taken on a rising edge with cmd_valid && cmd_ready;
  // cmd_ready is high only in IDLE, so nothing is sampled while busy.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      cmd_ready <= 1'b0;
      busy      <= 1'b0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      x_cur     <= '0;
      x_first   <= '0;
      x_last    <= '0;
      y_cur     <= '0;
      y_last    <= '0;
      row_base  <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
          wr_en     <= 1'b0;
          if (cmd_valid && cmd_ready) begin
            if (reject) begin
              err <= 1'b1;
            end else begin
              // First pixel goes out straight from the accept edge.
              state     <= FILL;
              cmd_ready <= 1'b0;
              busy      <= 1'b1;
              wr_en     <= 1'b1;
              wr_addr   <= 17'(y_lo) * W17 + 17'(x_lo);
              wr_data   <= cmd_color;
              x_cur     <= x_lo;
              x_first   <= x_lo;
              x_last    <= x_hi;
              y_cur     <= y_lo;
              y_last    <= y_hi;
              row_base  <= 17'(y_lo) * W17;
            end
          end
        end
        FILL: begin
          if (x_cur == x_last && y_cur == y_last) begin
            wr_en <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else if (x_cur == x_last) begin
            x_cur    <= x_first;
            y_cur    <= y_cur + 8'd1;
            row_base <= row_base + W17;
            wr_addr  <= row_base + W17 + 17'(x_first);
          end else begin
            x_cur   <= x_cur + 9'd1;
            wr_addr <= row_base + 17'(x_cur) + 17'd1;
          end
        end
        DONE: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fb_writer.sv
// Bench for fb_writer: table of commands checked against a raster model
// through an expected-write queue, plus hand sequences for the timing corners.
`timescale 1ns/1ps
module tb_fb_writer;

  localparam int W = 320;
  localparam int H = 240;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = '0;
  logic [8:0]  cmd_x0 = '0, cmd_x1 = '0;
  logic [7:0]  cmd_y0 = '0, cmd_y1 = '0;
  logic [7:0]  cmd_color = '0;
  logic        wr_en;
  logic [16:0] wr_addr;
  logic [7:0]  wr_data;
  logic        busy, done, err;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad = 0;
  int wr_cnt = 0;
  logic [24:0] exp_q[$];

  typedef struct {
    string      name;
    logic [1:0] op;
    logic [8:0] x0, x1;
    logic [7:0] y0, y1, color;
    int         exp_n;
  } vec_t;

  vec_t vecs[13];

  fb_writer #(.WIDTH(W), .HEIGHT(H)) dut (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_x0(cmd_x0), .cmd_x1(cmd_x1), .cmd_y0(cmd_y0),
    .cmd_y1(cmd_y1), .cmd_color(cmd_color), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy), .done(done), .err(err), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clock = ~clock;

  // scoreboard: every write must match the head of the expected queue
  always @(negedge clock) begin
    if (wr_en === 1'b1) begin
      total++;
      wr_cnt++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL write_unexpected: got addr=%0d data=%0h, expected no write", wr_addr, wr_data);
      end else begin
        logic [24:0] e;
        e = exp_q.pop_front();
        if ({wr_addr, wr_data} !== e) begin
          bad++;
          $display("FAIL write: got addr=%0d data=%0h, expected addr=%0d data=%0h",
                   wr_addr, wr_data, e[24:8], e[7:0]);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string name, input logic [1:0] op,
                              input logic [8:0] x0, input logic [8:0] x1,
                              input logic [7:0] y0, input logic [7:0] y1,
                              input logic [7:0] color, input int exp_n);
    vec_t v;
    v.name = name; v.op = op; v.x0 = x0; v.x1 = x1;
    v.y0 = y0; v.y1 = y1; v.color = color; v.exp_n = exp_n;
    return v;
  endfunction

  // reference model: pushes the raster-ordered writes; n = -1 means rejected
  task automatic model(input logic [1:0] op, input int x0, input int x1,
                       input int y0, input int y1, input logic [7:0] c, output int n);
    int xa, xb, ya, yb;
    n = 0;
    xa = x0; xb = x0; ya = y0; yb = y0;
    if (op == 2'd1) begin
      xb = (x1 > W - 1) ? W - 1 : x1;
      yb = (y1 > H - 1) ? H - 1 : y1;
    end else if (op == 2'd2) begin
      xa = 0; xb = W - 1; ya = 0; yb = H - 1;
    end
    if (op == 2'd3 || xa >= W || ya >= H || xa > xb || ya > yb) begin
      n = -1;
      return;
    end
    for (int y = ya; y <= yb; y++)
      for (int x = xa; x <= xb; x++) begin
        exp_q.push_back({17'(y * W + x), c});
        n++;
      end
  endtask

  // driver: call at a negedge; returns 1ns after the accept edge
  task automatic send(input logic [1:0] op, input logic [8:0] x0, input logic [8:0] x1,
                      input logic [7:0] y0, input logic [7:0] y1, input logic [7:0] c);
    int guard;
    cmd_op = op; cmd_x0 = x0; cmd_x1 = x1; cmd_y0 = y0; cmd_y1 = y1; cmd_color = c;
    cmd_valid = 1'b1;
    guard = 0;
    while (cmd_ready !== 1'b1 && guard < 1000) begin
      @(negedge clock);
      guard++;
    end
    if (cmd_ready !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got cmd_ready=%0b, expected 1", cmd_ready);
    end
    @(posedge clock);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic run_cmd(input string name, input logic [1:0] op, input logic [8:0] x0,
                         input logic [8:0] x1, input logic [7:0] y0, input logic [7:0] y1,
                         input logic [7:0] c, input int exp_n);
    int n, cyc, busy_low;
    bit seen;
    model(op, int'(x0), int'(x1), int'(y0), int'(y1), c, n);
    wr_cnt = 0;
    send(op, x0, x1, y0, y1, c);
    if (exp_n < 0) begin
      @(negedge clock);
      check({name, "_err"}, err, 1);
      check({name, "_no_wr"}, wr_en, 0);
      check({name, "_ready"}, cmd_ready, 1);
      check({name, "_state"}, dbg_state, 0);
      @(negedge clock);
      check({name, "_err_pulse"}, err, 0);
      check({name, "_no_done"}, done, 0);
      #1 check({name, "_wr_cnt"}, wr_cnt, 0);
    end else begin
      cyc = 0; busy_low = 0; seen = 0;
      while (!seen && cyc < exp_n + 10) begin
        @(negedge clock);
        cyc++;
        if (done === 1'b1) seen = 1;
        else if (busy !== 1'b1) busy_low++;
      end
      check({name, "_done_seen"}, seen, 1);
      check({name, "_done_cycle"}, cyc, exp_n + 1);
      check({name, "_ready_at_done"}, cmd_ready, 0);
      check({name, "_busy_held"}, busy_low, 0);
      #1 check({name, "_wr_cnt"}, wr_cnt, exp_n);
      @(negedge clock);
      check({name, "_ready_after"}, cmd_ready, 1);
      check({name, "_done_pulse"}, done, 0);
    end
    check({name, "_q_empty"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin : watchdog
    #5000000;
    bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : main
    int n;
    // y1 is 8 bits, so the oversize row bound uses 255 to exercise clipping.
    vecs[0]  = mk("pixel_5_2",    2'd0, 9'd5,   9'd3,   8'd2,   8'd1,   8'hAB, 1);
    vecs[1]  = mk("fill_clip",    2'd1, 9'd318, 9'd400, 8'd238, 8'd255, 8'h1C, 4);
    vecs[2]  = mk("fill_small",   2'd1, 9'd10,  9'd13,  8'd3,   8'd5,   8'h5A, 12);
    vecs[3]  = mk("fill_1x1",     2'd1, 9'd0,   9'd0,   8'd0,   8'd0,   8'h77, 1);
    vecs[4]  = mk("pixel_max",    2'd0, 9'd319, 9'd0,   8'd239, 8'd0,   8'hFF, 1);
    vecs[5]  = mk("fill_xclip",   2'd1, 9'd300, 9'd511, 8'd10,  8'd11,  8'h42, 40);
    vecs[6]  = mk("pixel_x320",   2'd0, 9'd320, 9'd0,   8'd0,   8'd0,   8'h11, -1);
    vecs[7]  = mk("fill_x0gtx1",  2'd1, 9'd10,  9'd5,   8'd0,   8'd0,   8'h22, -1);
    vecs[8]  = mk("op_reserved",  2'd3, 9'd1,   9'd2,   8'd1,   8'd2,   8'h33, -1);
    vecs[9]  = mk("fill_y240",    2'd1, 9'd0,   9'd5,   8'd240, 8'd245, 8'h44, -1);
    vecs[10] = mk("fill_y0gty1",  2'd1, 9'd1,   9'd2,   8'd9,   8'd8,   8'h55, -1);
    vecs[11] = mk("pixel_y240",   2'd0, 9'd3,   9'd0,   8'd240, 8'd0,   8'h66, -1);
    vecs[12] = mk("clear",        2'd2, 9'd77,  9'd3,   8'd99,  8'd4,   8'h00, W * H);

    // reset state
    @(negedge clock);
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", cmd_ready, 0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("post_rst_ready", cmd_ready, 1);
    check("post_rst_busy", busy, 0);
    check("post_rst_state", dbg_state, 0);

    // reset beats a simultaneous valid command
    cmd_op = 2'd0; cmd_x0 = 9'd1; cmd_y0 = 8'd1; cmd_color = 8'h99;
    cmd_valid = 1'b1; reset = 1'b1;
    @(negedge clock);
    check("rst_prio_wr_en", wr_en, 0);
    check("rst_prio_busy", busy, 0);
    check("rst_prio_ready", cmd_ready, 0);
    cmd_valid = 1'b0; reset = 1'b0;
    @(negedge clock);
    check("rst_prio_ready_after", cmd_ready, 1);

    // table-driven commands
    for (int i = 0; i < 13; i++) begin
      run_cmd(vecs[i].name, vecs[i].op, vecs[i].x0, vecs[i].x1,
              vecs[i].y0, vecs[i].y1, vecs[i].color, vecs[i].exp_n);
    end

    // random small commands, some rejected
    for (int i = 0; i < 4; i++) begin
      logic [1:0] op;
      logic [8:0] x0, x1;
      logic [7:0] y0, y1, c;
      op = 2'($urandom_range(0, 2));
      if (op == 2'd2) op = 2'd3;
      x0 = 9'($urandom_range(0, 325));
      x1 = ($urandom_range(0, 3) == 0) ? 9'($urandom_range(0, int'(x0)))
                                       : 9'(int'(x0) + $urandom_range(0, 60));
      y0 = 8'($urandom_range(0, 243));
      y1 = 8'(int'(y0) + $urandom_range(0, 2));
      c  = 8'($urandom_range(0, 255));
      model(op, int'(x0), int'(x1), int'(y0), int'(y1), c, n);
      exp_q.delete();
      run_cmd("random", op, x0, x1, y0, y1, c, n);
    end

    // second fill held valid during the first one
    model(2'd1, 2, 3, 1, 2, 8'h11, n);
    model(2'd1, 7, 8, 4, 4, 8'h22, n);
    wr_cnt = 0;
    send(2'd1, 9'd2, 9'd3, 8'd1, 8'd2, 8'h11);
    cmd_op = 2'd1; cmd_x0 = 9'd7; cmd_x1 = 9'd8; cmd_y0 = 8'd4; cmd_y1 = 8'd4;
    cmd_color = 8'h22; cmd_valid = 1'b1;
    for (int cyc = 1; cyc <= 9; cyc++) begin
      @(negedge clock);
      if (cyc <= 4) check("b2b_first_writes", wr_en, 1);
      if (cyc == 5) begin
        check("b2b_done_a", done, 1);
        check("b2b_ready_at_done", cmd_ready, 0);
      end
      if (cyc == 6) begin
        check("b2b_ready_after_done", cmd_ready, 1);
        check("b2b_idle_gap", wr_en, 0);
      end
      if (cyc == 7) begin
        check("b2b_second_first_wr", wr_en, 1);
        check("b2b_second_addr", wr_addr, 4 * W + 7);
        check("b2b_second_busy", busy, 1);
        cmd_valid = 1'b0;
      end
      if (cyc == 9) check("b2b_done_b", done, 1);
    end
    #1 check("b2b_wr_cnt", wr_cnt, 6);
    check("b2b_q_empty", exp_q.size(), 0);
    exp_q.delete();

    // reset partway through a clear
    @(negedge clock);
    for (int i = 0; i < 100; i++) exp_q.push_back({17'(i), 8'h3C});
    wr_cnt = 0;
    send(2'd2, 9'd0, 9'd0, 8'd0, 8'd0, 8'h3C);
    for (int cyc = 1; cyc <= 100; cyc++) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("abort_wr_en", wr_en, 0);
    check("abort_done", done, 0);
    check("abort_ready", cmd_ready, 0);
    reset = 1'b0;
    @(negedge clock);
    check("abort_ready_after", cmd_ready, 1);
    check("abort_no_done", done, 0);
    check("abort_no_wr", wr_en, 0);
    check("abort_state", dbg_state, 0);
    #1 check("abort_wr_cnt", wr_cnt, 100);
    check("abort_q_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
